// File: rtl/fc_result_reader.sv
// fc_result_reader: after the FC block finishes, sweeps SRAM f one word per
// cycle, finds the highest signed score, and presents its index and value
// with a valid/ready handshake.
module fc_result_reader #(
    parameter int DATA_WIDTH             = 8,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4,
    parameter int NUM_CLASS              = 10
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         fc2_done,
    output logic [1:0]                                   sram_raddr_f,
    input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata_f,
    output logic                                         class_valid,
    input  logic                                         class_ready,
    output logic [3:0]                                   class_id,
    output logic signed [DATA_WIDTH-1:0]                 class_score,
    output logic                                         busy,
    output logic                                         overrun
);

    localparam int NUM_WORDS = (NUM_CLASS + DATA_NUM_PER_SRAM_ADDR - 1) / DATA_NUM_PER_SRAM_ADDR;
    localparam logic [1:0] LAST_ADDR = 2'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

    // With a single word the only address is issued on the start edge itself
    localparam state_t FIRST_STATE = (NUM_WORDS == 1) ? DRAIN : READ;

    state_t state, next_state;

    logic                         accept;
    logic                         start;
    logic                         issue;
    logic                         addr_issued;
    logic                         rdata_valid;
    logic [1:0]                   rdata_addr;
    logic signed [DATA_WIDTH-1:0] lane [DATA_NUM_PER_SRAM_ADDR];
    logic signed [DATA_WIDTH-1:0] best_score;
    logic [3:0]                   best_id;

    assign class_valid = (state == OUT);
    assign busy        = (state != IDLE);
    assign accept      = (state == OUT) && class_ready;
    assign start       = fc2_done && ((state == IDLE) || accept);
    assign issue       = start || (state == READ);

    // Lane k of a word holds score 4*addr+k, with lane 0 in the top bits
    for (genvar k = 0; k < DATA_NUM_PER_SRAM_ADDR; k++) begin : g_lane
        assign lane[k] = sram_rdata_f[DATA_WIDTH*(DATA_NUM_PER_SRAM_ADDR-k)-1 -: DATA_WIDTH];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a run is READ while addresses remain, DRAIN until the last word is reduced
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FIRST_STATE;
            READ:    if (sram_raddr_f + 2'd1 == LAST_ADDR) next_state = DRAIN;
            DRAIN:   if (rdata_valid && (rdata_addr == LAST_ADDR)) next_state = OUT;
            OUT:     if (accept) next_state = start ? FIRST_STATE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Fold one word into the running maximum; score 0 seeds it and only strictly larger scores win ties
    always_comb begin
        best_score = class_score;
        best_id    = class_id;
        for (int k = 0; k < DATA_NUM_PER_SRAM_ADDR; k++) begin
            if ((int'(rdata_addr) * DATA_NUM_PER_SRAM_ADDR + k) < NUM_CLASS) begin
                if (((rdata_addr == 2'd0) && (k == 0)) || (lane[k] > best_score)) begin
                    best_score = lane[k];
                    best_id    = 4'(int'(rdata_addr) * DATA_NUM_PER_SRAM_ADDR + k);
                end
            end
        end
    end

    // Address generation, read-valid pipe, running maximum and overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_raddr_f <= 2'd0;
            addr_issued  <= 1'b0;
            rdata_valid  <= 1'b0;
            rdata_addr   <= 2'd0;
            class_id     <= 4'd0;
            class_score  <= '0;
            overrun      <= 1'b0;
        end else begin
            overrun     <= fc2_done && busy && !accept;
            addr_issued <= issue;
            rdata_valid <= addr_issued;
            rdata_addr  <= sram_raddr_f;
            if (issue) begin
                sram_raddr_f <= start ? 2'd0 : sram_raddr_f + 2'd1;
            end
            if (rdata_valid) begin
                class_score <= best_score;
                class_id    <= best_id;
            end
        end
    end

endmodule

// File: tb/tb_fc_result_reader.sv
// tb_fc_result_reader: directed and randomized runs of fc_result_reader
// against a plain argmax model and a registered-read SRAM model.
module tb_fc_result_reader;

    localparam int DW    = 8;
    localparam int NPA   = 4;
    localparam int NCLS  = 10;
    localparam int NWORD = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                fc2_done;
    logic [1:0]          sram_raddr_f;
    logic [NPA*DW-1:0]   sram_rdata_f;
    logic                class_valid;
    logic                class_ready;
    logic [3:0]          class_id;
    logic signed [DW-1:0] class_score;
    logic                busy;
    logic                overrun;

    logic [NPA*DW-1:0]   mem [NWORD];
    logic signed [DW-1:0] scores [NWORD*NPA];

    int checks   = 0;
    int failures = 0;
    int expId;
    int expScore;
    bit pending;

    fc_result_reader #(
        .DATA_WIDTH(DW),
        .DATA_NUM_PER_SRAM_ADDR(NPA),
        .NUM_CLASS(NCLS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fc2_done(fc2_done),
        .sram_raddr_f(sram_raddr_f),
        .sram_rdata_f(sram_rdata_f),
        .class_valid(class_valid),
        .class_ready(class_ready),
        .class_id(class_id),
        .class_score(class_score),
        .busy(busy),
        .overrun(overrun)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // SRAM f: data for the sampled address appears one cycle later
    always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Pack the 12 scores into words (index 4a+k in byte k from the top) and compute the argmax
    task automatic applyStimulus();
        for (int a = 0; a < NWORD; a++) begin
            mem[a] = '0;
            for (int k = 0; k < NPA; k++) begin
                mem[a][DW*(NPA-k)-1 -: DW] = scores[a*NPA+k];
            end
        end
        expId    = 0;
        expScore = scores[0];
        for (int i = 1; i < NCLS; i++) begin
            if (int'(scores[i]) > expScore) begin
                expId    = i;
                expScore = scores[i];
            end
        end
    endtask

    task automatic setScores(input int s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, p10, p11);
        scores[0] = 8'(s0);  scores[1] = 8'(s1);  scores[2]  = 8'(s2);  scores[3]  = 8'(s3);
        scores[4] = 8'(s4);  scores[5] = 8'(s5);  scores[6]  = 8'(s6);  scores[7]  = 8'(s7);
        scores[8] = 8'(s8);  scores[9] = 8'(s9);  scores[10] = 8'(p10); scores[11] = 8'(p11);
        applyStimulus();
    endtask

    // fc2_done (and possibly class_ready) is being driven for cycle 0; walk to cycle 5 and check the result
    task automatic awaitResult(input string tag);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin
                fc2_done    = 1'b0;
                class_ready = 1'b0;
                checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
                checkOutput({tag, "_ovr0"}, 32'(overrun), 32'd0);
            end
            if (c < 5) begin
                checkOutput({tag, "_early_valid"}, 32'(class_valid), 32'd0);
            end else begin
                checkOutput({tag, "_valid"}, 32'(class_valid), 32'd1);
                checkOutput({tag, "_id"}, 32'(class_id), 32'(expId));
                checkOutput({tag, "_score"}, 32'($signed(class_score)), 32'(expScore));
            end
        end
    endtask

    task automatic acceptResult(input string tag);
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
        checkOutput({tag, "_valid_after_acc"}, 32'(class_valid), 32'd0);
        checkOutput({tag, "_busy_after_acc"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        fc2_done    = 1'b0;
        class_ready = 1'b0;
        for (int a = 0; a < NWORD; a++) mem[a] = '0;
        tick();
        tick();
        checkOutput("rst_valid", 32'(class_valid), 32'd0);
        checkOutput("rst_raddr", 32'(sram_raddr_f), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_id", 32'(class_id), 32'd0);
        checkOutput("rst_score", 32'($signed(class_score)), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_raddr", 32'(sram_raddr_f), 32'd0);

        // Distinct maximum, then backpressure for 6 cycles
        setScores(3, -5, 7, 100, 0, 1, 2, -128, 9, 4, 0, 0);
        fc2_done = 1'b1;
        awaitResult("distinct");
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput("bp_valid", 32'(class_valid), 32'd1);
            checkOutput("bp_id", 32'(class_id), 32'd3);
            checkOutput("bp_score", 32'($signed(class_score)), 32'd100);
        end
        acceptResult("bp");
        checkOutput("idle_hold_id", 32'(class_id), 32'd3);

        // All negative with a tie at the maximum
        setScores(-9, -2, -7, -2, -50, -3, -4, -8, -6, -5, 0, 0);
        fc2_done = 1'b1;
        awaitResult("negtie");
        acceptResult("negtie");

        // Padding bytes larger than every valid score must be ignored
        setScores(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 127, 127);
        fc2_done = 1'b1;
        awaitResult("pad");
        acceptResult("pad");

        // Second fc2_done in cycle 2 is dropped with an overrun pulse
        setScores(3, -5, 7, 100, 0, 1, 2, -128, 9, 4, 0, 0);
        fc2_done = 1'b1;
        tick();
        fc2_done = 1'b0;
        tick();
        fc2_done = 1'b1;
        tick();
        fc2_done = 1'b0;
        checkOutput("ovr_pulse", 32'(overrun), 32'd1);
        tick();
        checkOutput("ovr_clear", 32'(overrun), 32'd0);
        checkOutput("ovr_valid4", 32'(class_valid), 32'd0);
        tick();
        checkOutput("ovr_valid", 32'(class_valid), 32'd1);
        checkOutput("ovr_id", 32'(class_id), 32'd3);
        checkOutput("ovr_score", 32'($signed(class_score)), 32'd100);
        acceptResult("ovr");

        // Reset in cycle 3 aborts the run
        fc2_done = 1'b1;
        tick();
        fc2_done = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("abort_valid", 32'(class_valid), 32'd0);
        checkOutput("abort_raddr", 32'(sram_raddr_f), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            checkOutput("abort_no_valid", 32'(class_valid), 32'd0);
            checkOutput("abort_no_read", 32'(sram_raddr_f), 32'd0);
        end

        // Random runs, sometimes starting the next run on the accepting cycle
        pending = 1'b0;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < NWORD*NPA; i++) scores[i] = 8'($urandom_range(0, 255));
            if ((it % 5) == 2) begin
                for (int i = 1; i < NCLS; i++) scores[i] = scores[0];
            end
            applyStimulus();
            fc2_done = 1'b1;
            if (pending) class_ready = 1'b1;
            awaitResult("rand");
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
                tick();
                checkOutput("rand_hold_id", 32'(class_id), 32'(expId));
            end
            pending = ($urandom_range(0, 1) == 1);
            if (!pending) acceptResult("rand");
        end
        if (pending) acceptResult("rand_last");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_result_reader.md
FC_RESULT_READER -- requirements
Module: fc_result_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one signed FC2 output score.
REQ-002 SHALL have parameter DATA_NUM_PER_SRAM_ADDR, default 4, scores packed per SRAM f word.
REQ-003 SHALL have parameter NUM_CLASS, default 10, number of valid scores in SRAM f, at indices 0..NUM_CLASS-1.
REQ-004 SHALL have port clk, input, 1, the only clock; all flops on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port fc2_done, input, 1, one-cycle pulse from the FC block meaning SRAM f is fully written.
REQ-007 SHALL have port sram_raddr_f, output, 2, SRAM f read address, registered.
REQ-008 SHALL have port sram_rdata_f, input, DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH, SRAM f read data, valid one cycle after the address is sampled.
REQ-009 SHALL have port class_valid, output, 1, result available.
REQ-010 SHALL have port class_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port class_id, output, 4, index of the maximum score.
REQ-012 SHALL have port class_score, output, DATA_WIDTH, the maximum score, signed two's complement.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port overrun, output, 1, one-cycle pulse when fc2_done arrives while busy.

Function
REQ-015 SHALL implement states IDLE, READ, DRAIN and OUT.
- IDLE -> READ on fc2_done.
- READ -> DRAIN after issuing the last address.
- DRAIN -> OUT when the last word is compared.
- OUT -> IDLE on class_valid && class_ready.
REQ-016 SHALL, on the fc2_done edge in IDLE, drive sram_raddr_f=0, then 1, 2, ... on successive edges up to ceil(NUM_CLASS/DATA_NUM_PER_SRAM_ADDR)-1 (2 at defaults).
REQ-017 SHALL track each issued address with a 1-cycle valid pipe and compare sram_rdata_f only in cycles where that pipe is high.
REQ-018 SHALL map score index 4*addr+k to sram_rdata_f bits [DATA_WIDTH*(DATA_NUM_PER_SRAM_ADDR-k)-1 -: DATA_WIDTH], so k=0 is the MSB byte.
REQ-019 SHALL ignore score indices >= NUM_CLASS (indices 10 and 11 at defaults).
REQ-020 SHALL reduce one full word per cycle against the running maximum using signed comparison.
REQ-021 SHALL break ties in favour of the lowest index, i.e. replace the running maximum only when a score is strictly greater.
REQ-022 SHALL initialise the running maximum from index 0 (not from a constant) at the start of each run.
REQ-023 SHALL have fixed latency at defaults: fc2_done high in cycle 0 -> class_valid high from cycle 5.
REQ-024 SHALL hold class_valid, class_id and class_score stable while class_valid && !class_ready.
REQ-025 SHALL deassert class_valid on the edge where class_ready is sampled high and return to IDLE.
REQ-026 SHALL start a new run on an fc2_done that coincides with the accepting handshake cycle.
REQ-027 SHALL, on fc2_done while busy and not in that accepting cycle, ignore the pulse, pulse overrun for one cycle, and leave the current run unaffected.
REQ-028 SHALL hold sram_raddr_f at its last value outside READ.
REQ-029 SHALL hold class_id and class_score at their last result in IDLE; they are meaningful only when class_valid is high.

Reset
REQ-030 SHALL, while rst is high, force IDLE, sram_raddr_f=0, class_valid=0, class_id=0, class_score=0, busy=0, overrun=0, and clear the valid pipe and running maximum, independent of clk.
REQ-031 SHALL abort any in-progress run on rst assertion, with no partial result ever presented.
REQ-032 SHALL require a new fc2_done after rst deasserts before any read is issued.

Verification
REQ-033 SHALL cover distinct maximum: scores {3,-5,7,100,0,1,2,-128,9,4}, fc2_done -> class_id=3, class_score=100, class_valid in cycle 5.
REQ-034 SHALL cover all-negative with tie: scores {-9,-2,-7,-2,-50,-3,-4,-8,-6,-5} -> class_id=1, class_score=-2.
REQ-035 SHALL cover padding bytes: word 2 bytes k=2,3 set to 127, valid scores all 0 -> class_id=0, class_score=0.
REQ-036 SHALL cover backpressure: class_ready low 6 cycles after class_valid, then high -> outputs stable 6 cycles, class_valid low next cycle, busy low.
REQ-037 SHALL cover overrun and reset: second fc2_done in cycle 2 -> overrun pulse in cycle 3, result unchanged; separately rst in cycle 3 -> class_valid never asserts, sram_raddr_f=0.
